// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Holds the in-flight stage record, the operand-source encodings and the default widths.
package hazard_pkg;

  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_NUM_SRC    = 3;
  localparam int DEF_DEPTH      = 2;
  localparam int DEF_CNT_W      = 16;

  // Records carry a fixed-width destination; narrower register files zero-extend into it.
  localparam int MAX_REG_ADDR_W = 8;

  localparam int FWD_W = 3;
  localparam logic [FWD_W-1:0] FWD_RF  = 3'd0;
  localparam logic [FWD_W-1:0] FWD_EXE = 3'd1;
  localparam logic [FWD_W-1:0] FWD_MEM = 3'd2;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] dest;
    logic                      wb_en;
    logic                      load;
  } stage_rec_t;

  localparam stage_rec_t STAGE_EMPTY = '0;

endpackage

// File: rtl/hazard_stage_tracker.sv
// DEPTH-entry shift register of in-flight instruction records behind ID.
// Entry 0 is stage 1 (EXE); flush empties every entry at the next edge.
module hazard_stage_tracker
  import hazard_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  stage_rec_t             rec_i,
  output stage_rec_t [DEPTH-1:0] stage_o
);

  stage_rec_t [DEPTH-1:0] stage_q;
  stage_rec_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = STAGE_EMPTY;
      end
    end else begin
      stage_d[0] = push_i ? rec_i : STAGE_EMPTY;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard detection and forwarding-source selection for an in-order pipeline.
// Stall, issue_ready and fwd_sel are combinational so a hazard holds ID in the same cycle.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int NUM_SRC    = DEF_NUM_SRC,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                issue_valid,
  output logic                                issue_ready,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]                  src_used,
  input  logic [REG_ADDR_W-1:0]               dest_addr,
  input  logic                                wb_en,
  input  logic                                mem_r_en,
  input  logic                                forward_en,
  input  logic                                flush,
  output logic                                stall,
  output logic [NUM_SRC-1:0][FWD_W-1:0]       fwd_sel,
  output logic [CNT_W-1:0]                    stall_count
);

  stage_rec_t [DEPTH-1:0]           stage_s;
  stage_rec_t                       new_rec_s;
  logic                             push_s;
  logic [NUM_SRC-1:0][DEPTH-1:0]    match_s;
  logic [NUM_SRC-1:0][FWD_W-1:0]    pick_s;
  logic                             raw_any_s;
  logic                             load_use_s;
  logic                             hazard_s;
  logic                             quiet_s;
  logic                             unused_load_s;
  logic [CNT_W-1:0]                 cnt_q;
  logic [CNT_W-1:0]                 cnt_d;

  always_comb begin
    new_rec_s       = STAGE_EMPTY;
    new_rec_s.valid = 1'b1;
    new_rec_s.dest  = MAX_REG_ADDR_W'(dest_addr);
    new_rec_s.wb_en = wb_en;
    new_rec_s.load  = mem_r_en;
  end

  hazard_stage_tracker #(
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .push_i  (push_s),
    .rec_i   (new_rec_s),
    .stage_o (stage_s)
  );

  // Per-source compare against every stage; the youngest matching producer wins.
  always_comb begin
    match_s       = '0;
    pick_s        = '0;
    raw_any_s     = 1'b0;
    load_use_s    = 1'b0;
    unused_load_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      unused_load_s = unused_load_s ^ stage_s[k].load;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        match_s[i][k] = src_used[i] & stage_s[k].valid & stage_s[k].wb_en &
                        (stage_s[k].dest == MAX_REG_ADDR_W'(src_addr[i]));
      end
      for (int k = DEPTH - 1; k >= 0; k--) begin
        pick_s[i] = match_s[i][k] ? FWD_W'(k + 1) : pick_s[i];
      end
      raw_any_s  = raw_any_s | (|match_s[i]);
      load_use_s = load_use_s | ((pick_s[i] == FWD_EXE) & stage_s[0].load);
    end
  end

  // Reset and flush cycles never stall and never forward.
  always_comb begin
    quiet_s     = rst | flush;
    hazard_s    = forward_en ? load_use_s : raw_any_s;
    stall       = issue_valid & ~quiet_s & hazard_s;
    issue_ready = issue_valid & ~stall;
    push_s      = issue_ready & ~flush;
    if (forward_en && !quiet_s) begin
      fwd_sel = pick_s;
    end else begin
      fwd_sel = '0;
    end
  end

  always_comb begin
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int AW      = 4;
  localparam int NS      = 3;
  localparam int DP      = 2;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic                  clk;
  logic                  rst;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [NS-1:0][AW-1:0] src_addr;
  logic [NS-1:0]         src_used;
  logic [AW-1:0]         dest_addr;
  logic                  wb_en;
  logic                  mem_r_en;
  logic                  forward_en;
  logic                  flush;
  logic                  stall;
  logic [NS-1:0][2:0]    fwd_sel;
  logic [CW-1:0]         stall_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit valid;
    int dest;
    bit wb;
    bit load;
  } rec_t;

  rec_t               pipe[$];   // index 0 = youngest in-flight instruction
  int                 m_count;
  bit                 exp_stall;
  logic [NS-1:0][2:0] exp_fwd;

  hazard_scoreboard #(
    .REG_ADDR_W (AW),
    .NUM_SRC    (NS),
    .DEPTH      (DP),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .src_addr    (src_addr),
    .src_used    (src_used),
    .dest_addr   (dest_addr),
    .wb_en       (wb_en),
    .mem_r_en    (mem_r_en),
    .forward_en  (forward_en),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_eval();
    int sel[NS];
    bit hz;
    hz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      sel[i] = 0;
      if (src_used[i]) begin
        for (int k = 0; k < pipe.size(); k++) begin
          if (pipe[k].valid && pipe[k].wb && pipe[k].dest == int'(src_addr[i])) begin
            sel[i] = k + 1;
            break;
          end
        end
      end
      if (forward_en) begin
        if (sel[i] == 1 && pipe[0].load) hz = 1'b1;
      end else if (sel[i] != 0) begin
        hz = 1'b1;
      end
    end
    exp_stall = issue_valid && !rst && !flush && hz;
    for (int i = 0; i < NS; i++) begin
      exp_fwd[i] = (forward_en && !rst && !flush) ? 3'(sel[i]) : 3'd0;
    end
  endtask

  task automatic model_edge();
    rec_t r;
    r.valid = 1'b0; r.dest = 0; r.wb = 1'b0; r.load = 1'b0;
    if (rst || flush) begin
      pipe.delete();
      for (int k = 0; k < DP; k++) pipe.push_back(r);
      if (rst) m_count = 0;
    end else begin
      if (issue_valid && !exp_stall) begin
        r.valid = 1'b1; r.dest = int'(dest_addr); r.wb = wb_en; r.load = mem_r_en;
      end
      pipe.push_front(r);
      void'(pipe.pop_back());
      if (exp_stall && m_count < CNT_MAX) m_count++;
    end
  endtask

  task automatic settle_check(input string tag);
    #1;
    model_eval();
    check_eq({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    check_eq({tag, "_ready"}, 32'(issue_ready), 32'(issue_valid && !exp_stall));
    check_eq({tag, "_fwd"}, 32'(fwd_sel), 32'(exp_fwd));
    check_eq({tag, "_cnt"}, 32'(stall_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input int s0, input int s1, input int s2,
                        input logic [2:0] used, input int d, input bit wb, input bit ld);
    issue_valid = v;
    src_addr[0] = AW'(s0);
    src_addr[1] = AW'(s1);
    src_addr[2] = AW'(s2);
    src_used    = used;
    dest_addr   = AW'(d);
    wb_en       = wb;
    mem_r_en    = ld;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; forward_en = 1'b0;
    set_in(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0);
    m_count = 0;
    tick();
    settle_check("reset");
    check_eq("reset_cnt", 32'(stall_count), 32'd0);
    tick();
    rst = 1'b0;

    // state right after reset
    set_in(1'b1, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0);
    settle_check("post_rst");
    check_eq("post_rst_ready", 32'(issue_ready), 32'd1);
    check_eq("post_rst_fwd", 32'(fwd_sel), 32'd0);
    tick();

    // no-forward RAW: two stall cycles with DEPTH=2
    set_in(1'b1, 0, 0, 0, 3'b000, 1, 1'b1, 1'b0);
    settle_check("raw_prod"); tick();
    set_in(1'b1, 1, 1, 0, 3'b011, 4, 1'b0, 1'b0);
    settle_check("raw_c1");
    check_eq("raw_c1_stall", 32'(stall), 32'd1);
    tick();
    settle_check("raw_c2");
    check_eq("raw_c2_stall", 32'(stall), 32'd1);
    tick();
    settle_check("raw_go");
    check_eq("raw_go_stall", 32'(stall), 32'd0);
    check_eq("raw_go_ready", 32'(issue_ready), 32'd1);
    check_eq("raw_cnt", 32'(stall_count), 32'd2);
    tick();

    // forwarding priority: youngest producer wins
    forward_en = 1'b1;
    set_in(1'b1, 0, 0, 0, 3'b000, 1, 1'b1, 1'b0);
    settle_check("pri_p1"); tick();
    settle_check("pri_p2"); tick();
    set_in(1'b1, 1, 0, 0, 3'b001, 9, 1'b0, 1'b0);
    settle_check("pri");
    check_eq("pri_sel", 32'(fwd_sel), 32'h1);
    check_eq("pri_stall", 32'(stall), 32'd0);
    tick();

    // store operands from two different stages
    set_in(1'b1, 0, 0, 0, 3'b000, 1, 1'b1, 1'b0);
    settle_check("st_p1"); tick();
    set_in(1'b1, 0, 0, 0, 3'b000, 2, 1'b1, 1'b0);
    settle_check("st_p2"); tick();
    set_in(1'b1, 1, 2, 0, 3'b011, 0, 1'b0, 1'b0);
    settle_check("store");
    check_eq("store_sel", 32'(fwd_sel), 32'(9'b000_001_010));
    check_eq("store_stall", 32'(stall), 32'd0);
    tick();

    // immediates never hazard even when every stage matches
    forward_en = 1'b0;
    set_in(1'b1, 0, 0, 0, 3'b000, 0, 1'b1, 1'b0);
    settle_check("imm_p1"); tick();
    settle_check("imm_p2"); tick();
    set_in(1'b1, 0, 0, 0, 3'b000, 5, 1'b1, 1'b0);
    settle_check("imm");
    check_eq("imm_stall", 32'(stall), 32'd0);
    check_eq("imm_fwd", 32'(fwd_sel), 32'd0);
    tick();

    // load-use: one bubble, then forward from MEM
    forward_en = 1'b1;
    set_in(1'b1, 0, 0, 0, 3'b000, 3, 1'b1, 1'b1);
    settle_check("lu_ld"); tick();
    set_in(1'b1, 3, 0, 0, 3'b001, 6, 1'b1, 1'b0);
    settle_check("lu_c1");
    check_eq("lu_c1_stall", 32'(stall), 32'd1);
    tick();
    settle_check("lu_c2");
    check_eq("lu_c2_stall", 32'(stall), 32'd0);
    check_eq("lu_sel", 32'(fwd_sel), 32'h2);
    tick();

    // flush during a stall
    forward_en = 1'b0;
    set_in(1'b1, 0, 0, 0, 3'b000, 5, 1'b1, 1'b0);
    settle_check("fl_p"); tick();
    set_in(1'b1, 5, 0, 0, 3'b001, 6, 1'b0, 1'b0);
    settle_check("fl_c1");
    check_eq("fl_c1_stall", 32'(stall), 32'd1);
    tick();
    flush = 1'b1;
    settle_check("fl_now");
    check_eq("fl_now_stall", 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    settle_check("fl_after");
    check_eq("fl_after_stall", 32'(stall), 32'd0);
    check_eq("fl_after_ready", 32'(issue_ready), 32'd1);
    tick();

    // reset mid-stall
    set_in(1'b1, 0, 0, 0, 3'b000, 8, 1'b1, 1'b0);
    settle_check("rs_p"); tick();
    set_in(1'b1, 8, 0, 0, 3'b001, 6, 1'b0, 1'b0);
    settle_check("rs_c1");
    check_eq("rs_c1_stall", 32'(stall), 32'd1);
    tick();
    rst = 1'b1;
    settle_check("rs_now");
    check_eq("rs_now_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    settle_check("rs_go");
    check_eq("rs_cnt", 32'(stall_count), 32'd0);
    check_eq("rs_go_ready", 32'(issue_ready), 32'd1);
    tick();

    // saturation: self-dependent stream stalls two of every three cycles
    set_in(1'b1, 7, 0, 0, 3'b001, 7, 1'b1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      settle_check("sat");
      tick();
    end
    settle_check("sat_end");
    check_eq("sat_cnt", 32'(stall_count), 32'd15);
    tick();

    // randomized traffic; small address range keeps hazards frequent
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(99) < 2);
      flush       = ($urandom_range(99) < 5);
      forward_en  = 1'($urandom_range(1));
      issue_valid = ($urandom_range(99) < 80);
      for (int i = 0; i < NS; i++) src_addr[i] = AW'($urandom_range(3));
      src_used    = NS'($urandom);
      dest_addr   = AW'($urandom_range(3));
      wb_en       = 1'($urandom_range(1));
      mem_r_en    = ($urandom_range(99) < 30);
      settle_check("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
